memory_log: RTL

- Parametrised successor to the opening-record memory: a circular log of access records with write pointer, valid tracking, occupancy count and overflow policy.
- Registered random-access reads with a valid strobe.
- Sequential clear engine that zeroes the array in DEPTH cycles instead of a one-cycle mass reset.
- Sits between the lock controller, which appends records, and the display/audit path, which reads records back.

---
 rtl/memory_log.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/memory_log.sv
// Circular log of access records: appends at wr_ptr with valid tracking and an
// occupancy count, registered random-access reads, and a DEPTH-cycle clear sweep.
module memory_log #(
  parameter int DATA_W    = 17,
  parameter int ADDR_W    = 9,
  parameter int OVERWRITE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_idx,
  input  logic              clr_req,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              rd_hit,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              busy,
  output logic              wr_drop,
  output logic              overflow,
  output logic              state_dbg
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              wr_drop_q, wr_drop_d;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rd_hit_q;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              is_full;

  assign is_full = (count_q == FULL_CNT);

  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    valid_d    = valid_q;
    overflow_d = overflow_q;
    wr_drop_d  = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = wr_ptr_q;
    mem_wdata  = wdata;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          // Clear wins over a same-cycle append; the append is reported as dropped.
          state_d    = ST_CLEAR;
          sweep_d    = '0;
          valid_d    = '0;
          count_d    = '0;
          wr_ptr_d   = '0;
          overflow_d = 1'b0;
          wr_drop_d  = wr_en;
        end else if (wr_en) begin
          if (!is_full) begin
            mem_we            = 1'b1;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + 1'b1;
            count_d           = count_q + 1'b1;
          end else if (OVERWRITE != 0) begin
            mem_we     = 1'b1;
            wr_ptr_d   = wr_ptr_q + 1'b1;
            overflow_d = 1'b1;
          end else begin
            wr_drop_d  = 1'b1;
            overflow_d = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = sweep_q;
        mem_wdata = '0;
        sweep_d   = sweep_q + 1'b1;
        wr_drop_d = wr_en;
        if (&sweep_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      sweep_q    <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      overflow_q <= 1'b0;
      wr_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sweep_q    <= sweep_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      wr_drop_q  <= wr_drop_d;
    end
  end

  // Array contents are never reset; stale data is hidden by the valid bits.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Read port: rd_req sampled at an edge yields a one-cycle rd_valid pulse after it;
  // rdata/rd_hit are meaningful while rd_valid=1 and hold otherwise. Old data is
  // returned when the same index is written in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_valid_q <= 1'b0;
      rdata_q    <= '0;
      rd_hit_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_req;
      if (rd_req) begin
        if (state_q == ST_IDLE && valid_q[rd_idx]) begin
          rdata_q  <= mem_q[rd_idx];
          rd_hit_q <= 1'b1;
        end else begin
          rdata_q  <= '0;
          rd_hit_q <= 1'b0;
        end
      end
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rdata     = rdata_q;
  assign rd_hit    = rd_hit_q;
  assign wr_ptr    = wr_ptr_q;
  assign count     = count_q;
  assign full      = is_full;
  assign busy      = (state_q == ST_CLEAR);
  assign wr_drop   = wr_drop_q;
  assign overflow  = overflow_q;
  assign state_dbg = state_q;

endmodule
